// File: rtl/crc4_check.sv
// Serial CRC-3 (x^3+x+1) frame checker: collects a payload and its received CRC,
// recomputes the CRC over the payload and reports the verdict plus a saturating error count.
module crc4_check #(
    parameter int DATA_BITS = 9,
    parameter int CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_data_in,
    input  logic                 i_wr_en,
    input  logic                 i_abort,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic [2:0]           o_rx_crc,
    output logic [2:0]           o_calc_crc,
    output logic                 o_frame_valid,
    output logic                 o_crc_ok,
    output logic                 o_crc_err,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_err_count
);

    localparam int CW = ($clog2(DATA_BITS) > 2) ? $clog2(DATA_BITS) : 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    function automatic logic [2:0] crc_step(input logic [2:0] crc, input logic d);
        logic fb;
        fb = crc[2] ^ d;
        return {crc[1], crc[0] ^ fb, fb};
    endfunction

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_lfsr;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_crc_sh;
    logic [DATA_BITS-1:0] r_rx_data;
    logic [2:0]           r_rx_crc;
    logic [2:0]           r_calc_crc;
    logic                 r_frame_valid;
    logic                 r_crc_ok;
    logic                 r_crc_err;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_err_count;

    logic [DATA_BITS-1:0] w_shift_next;
    logic [2:0]           w_crc_full;
    logic                 w_match;

    // Next-value helpers shared by the state machine
    always_comb begin
        w_shift_next = (r_shift << 1) | DATA_BITS'(i_data_in);
        w_crc_full   = {r_crc_sh[1:0], i_data_in};
        w_match      = (w_crc_full == r_lfsr);
    end

    // Frame reception state machine with registered result outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_lfsr        <= 3'b000;
            r_shift       <= '0;
            r_crc_sh      <= 3'b000;
            r_rx_data     <= '0;
            r_rx_crc      <= 3'b000;
            r_calc_crc    <= 3'b000;
            r_frame_valid <= 1'b0;
            r_crc_ok      <= 1'b0;
            r_crc_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_crc_err     <= 1'b0;
            if (i_abort) begin
                // Same-cycle bit is dropped; previous results stay visible
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_lfsr   <= 3'b000;
                r_shift  <= '0;
                r_crc_sh <= 3'b000;
                r_busy   <= 1'b0;
            end else if (i_wr_en) begin
                case (r_state)
                    IDLE: begin
                        r_shift <= w_shift_next;
                        r_lfsr  <= crc_step(3'b000, i_data_in);
                        r_busy  <= 1'b1;
                        if (DATA_BITS == 1) begin
                            r_state <= CRC;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= DATA;
                            r_cnt   <= CW'(1);
                        end
                    end
                    DATA: begin
                        r_shift <= w_shift_next;
                        r_lfsr  <= crc_step(r_lfsr, i_data_in);
                        if (r_cnt == CW'(DATA_BITS - 1)) begin
                            r_state <= CRC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    CRC: begin
                        r_crc_sh <= w_crc_full;
                        if (r_cnt == CW'(2)) begin
                            r_state       <= IDLE;
                            r_cnt         <= '0;
                            r_lfsr        <= 3'b000;
                            r_busy        <= 1'b0;
                            r_rx_data     <= r_shift;
                            r_rx_crc      <= w_crc_full;
                            r_calc_crc    <= r_lfsr;
                            r_frame_valid <= 1'b1;
                            r_crc_ok      <= w_match;
                            r_crc_err     <= ~w_match;
                            if (!w_match && (r_err_count != {CNT_W{1'b1}})) begin
                                r_err_count <= r_err_count + CNT_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_lfsr  <= 3'b000;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_crc      = r_rx_crc;
    assign o_calc_crc    = r_calc_crc;
    assign o_frame_valid = r_frame_valid;
    assign o_crc_ok      = r_crc_ok;
    assign o_crc_err     = r_crc_err;
    assign o_busy        = r_busy;
    assign o_err_count   = r_err_count;

endmodule
